// File: rtl/cpu_input_capture_pio.sv
`default_nettype none
// ============================================================================
// Module   : cpu_input_capture_pio
// Brief    : Avalon-MM input PIO with synchroniser, edge capture (W1C),
//            saturating event counter and level interrupt.
// Revision : 1.0  initial release
// ============================================================================
module cpu_input_capture_pio #(
    parameter int DATA_WIDTH = 8,
    parameter int EDGE_TYPE  = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    localparam logic [1:0]           c_ADDR_DATA = 2'd0;
    localparam logic [1:0]           c_ADDR_CNT  = 2'd1;
    localparam logic [1:0]           c_ADDR_MASK = 2'd2;
    localparam logic [1:0]           c_ADDR_EDGE = 2'd3;
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE   = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_s1;
    logic [DATA_WIDTH-1:0] r_s2;
    logic [DATA_WIDTH-1:0] r_s3;
    logic [DATA_WIDTH-1:0] r_edgecapture;
    logic [DATA_WIDTH-1:0] r_irqmask;
    logic [CNT_WIDTH-1:0]  r_counter;
    logic [31:0]           r_readdata;

    logic [DATA_WIDTH-1:0] w_edge;
    logic [DATA_WIDTH-1:0] w_clear;
    logic                  w_write;
    logic                  w_any_edge;
    logic                  w_cnt_clear;
    logic [31:0]           w_read_mux;
    logic                  w_unused_wdata;

    assign w_write        = chipselect & ~write_n;
    assign w_cnt_clear    = w_write & (address == c_ADDR_CNT);
    assign w_clear        = (w_write && address == c_ADDR_EDGE) ? writedata[DATA_WIDTH-1:0] : '0;
    assign w_any_edge     = |w_edge;
    assign w_unused_wdata = ^writedata;

    generate
        if (EDGE_TYPE == 0) begin : g_rising
            assign w_edge = r_s2 & ~r_s3;
        end else if (EDGE_TYPE == 1) begin : g_falling
            assign w_edge = ~r_s2 & r_s3;
        end else begin : g_any
            assign w_edge = r_s2 ^ r_s3;
        end
    endgenerate

    // Two-flop synchroniser plus a history stage for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= in_port;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // A new edge beats a simultaneous write-one-to-clear on the same bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edgecapture <= '0;
        end else begin
            r_edgecapture <= w_edge | (r_edgecapture & ~w_clear);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irqmask <= '0;
        end else if (w_write && address == c_ADDR_MASK) begin
            r_irqmask <= writedata[DATA_WIDTH-1:0];
        end
    end

    // Clearing on an event cycle still counts that event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_counter <= '0;
        end else if (w_cnt_clear) begin
            r_counter <= w_any_edge ? c_CNT_ONE : '0;
        end else if (w_any_edge && r_counter != c_CNT_MAX) begin
            r_counter <= r_counter + c_CNT_ONE;
        end
    end

    always_comb begin
        w_read_mux = '0;
        case (address)
            c_ADDR_DATA: w_read_mux[DATA_WIDTH-1:0] = r_s2;
            c_ADDR_CNT:  w_read_mux[CNT_WIDTH-1:0]  = r_counter;
            c_ADDR_MASK: w_read_mux[DATA_WIDTH-1:0] = r_irqmask;
            default:     w_read_mux[DATA_WIDTH-1:0] = r_edgecapture;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_read_mux;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edgecapture & r_irqmask);

endmodule
`default_nettype wire

// File: tb/tb_cpu_input_capture_pio.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_input_capture_pio
// Brief    : Bench for three configurations of cpu_input_capture_pio against
//            a sample-history reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_input_capture_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in0;
    logic [3:0]  in1;
    logic [7:0]  in2;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-instance configuration: width, mode, counter width
    int dwv [3];
    int modev [3];
    int cwv [3];

    // Model: last three input samples (newest first) plus architectural registers
    int unsigned m_h0 [3];
    int unsigned m_h1 [3];
    int unsigned m_h2 [3];
    int unsigned m_ec [3];
    int unsigned m_mk [3];
    int unsigned m_cnt [3];
    int unsigned m_rd [3];

    always #5 clk = ~clk;

    cpu_input_capture_pio #(.DATA_WIDTH(8), .EDGE_TYPE(0), .CNT_WIDTH(16)) u_dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in0),
        .readdata(rd0), .irq(irq0));

    cpu_input_capture_pio #(.DATA_WIDTH(4), .EDGE_TYPE(1), .CNT_WIDTH(16)) u_dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in1),
        .readdata(rd1), .irq(irq1));

    cpu_input_capture_pio #(.DATA_WIDTH(8), .EDGE_TYPE(2), .CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in2),
        .readdata(rd2), .irq(irq2));

    function automatic int unsigned in_of(int m);
        case (m)
            0:       return {24'd0, in0};
            1:       return {28'd0, in1};
            default: return {24'd0, in2};
        endcase
    endfunction

    function automatic logic [31:0] dut_rd(int m);
        case (m)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    function automatic logic dut_irq(int m);
        case (m)
            0:       return irq0;
            1:       return irq1;
            default: return irq2;
        endcase
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            m_h0[m] = 0; m_h1[m] = 0; m_h2[m] = 0;
            m_ec[m] = 0; m_mk[m] = 0; m_cnt[m] = 0; m_rd[m] = 0;
        end
    endtask

    // One rising clock edge: data seen on the bus now, history gives s2/s3
    task automatic model_step();
        for (int m = 0; m < 3; m++) begin
            int unsigned dmask, cmax, ev, clr, nrd;
            bit wr;
            dmask = (dwv[m] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dwv[m]) - 1);
            cmax  = (cwv[m] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cwv[m]) - 1);
            wr    = chipselect && !write_n;
            case (modev[m])
                0:       ev = m_h1[m] & ~m_h2[m];
                1:       ev = ~m_h1[m] & m_h2[m];
                default: ev = m_h1[m] ^ m_h2[m];
            endcase
            ev = ev & dmask;
            case (address)
                2'd0:    nrd = m_h1[m];
                2'd1:    nrd = m_cnt[m];
                2'd2:    nrd = m_mk[m];
                default: nrd = m_ec[m];
            endcase
            clr = (wr && address == 2'd3) ? (writedata & dmask) : 0;
            if (wr && address == 2'd1)
                m_cnt[m] = (ev != 0) ? 1 : 0;
            else if (ev != 0 && m_cnt[m] < cmax)
                m_cnt[m] = m_cnt[m] + 1;
            m_ec[m] = ev | (m_ec[m] & ~clr);
            if (wr && address == 2'd2)
                m_mk[m] = writedata & dmask;
            m_rd[m] = nrd;
            m_h2[m] = m_h1[m];
            m_h1[m] = m_h0[m];
            m_h0[m] = in_of(m) & dmask;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (rd0 !== 32'd0 || rd1 !== 32'd0 || rd2 !== 32'd0)
            $display("FAIL reset_readdata: got %h %h %h expected 0", rd0, rd1, rd2); else n_pass++;
        n_checks++; if ({irq0, irq1, irq2} !== 3'b000)
            $display("FAIL reset_irq: got %b expected 000", {irq0, irq1, irq2}); else n_pass++;
        in0 = 8'hFF; in1 = 4'hF; in2 = 8'hFF;
        address = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (rd0 !== 32'd0 || rd1 !== 32'd0 || rd2 !== 32'd0)
            $display("FAIL reset_held_readdata: got %h %h %h expected 0", rd0, rd1, rd2); else n_pass++;
        n_checks++; if ({irq0, irq1, irq2} !== 3'b000)
            $display("FAIL reset_held_irq: got %b expected 000", {irq0, irq1, irq2}); else n_pass++;
        in0 = 8'h00; in1 = 4'h0; in2 = 8'h00;
        model_reset();
        reset = 1'b0;
    endtask

    task automatic test_rising_irq();
        wr_reg(2'd2, 32'h0000_0008);
        address = 2'd0;
        in0     = 8'h08;
        tick();
        n_checks++; if (irq0 !== 1'b0) $display("FAIL rising_irq_k: got %b expected 0", irq0); else n_pass++;
        tick();
        n_checks++; if (irq0 !== 1'b0) $display("FAIL rising_irq_k1: got %b expected 0", irq0); else n_pass++;
        tick();
        n_checks++; if (irq0 !== 1'b1) $display("FAIL rising_irq_k2: got %b expected 1", irq0); else n_pass++;
        n_checks++; if (rd0 !== 32'h08) $display("FAIL rising_data: got %h expected 00000008", rd0); else n_pass++;
        address = 2'd3;
        tick();
        n_checks++; if (rd0 !== 32'h08) $display("FAIL rising_edgecap: got %h expected 00000008", rd0); else n_pass++;
        address = 2'd1;
        tick();
        n_checks++; if (rd0 !== 32'h01) $display("FAIL rising_counter: got %h expected 00000001", rd0); else n_pass++;
    endtask

    task automatic test_w1c();
        wr_reg(2'd3, 32'h0000_0008);
        n_checks++; if (irq0 !== 1'b0) $display("FAIL w1c_irq: got %b expected 0", irq0); else n_pass++;
        n_checks++; if (rd0 !== 32'h08) $display("FAIL w1c_pre_read: got %h expected 00000008", rd0); else n_pass++;
        tick();
        n_checks++; if (rd0 !== 32'h00) $display("FAIL w1c_cleared: got %h expected 0", rd0); else n_pass++;
        in0 = 8'h00; repeat (3) tick();
        in0 = 8'h08; repeat (3) tick();
        in0 = 8'h00; repeat (3) tick();
        in0 = 8'h08; tick(); tick();
        wr_reg(2'd3, 32'h0000_0008);
        n_checks++; if (irq0 !== 1'b1) $display("FAIL w1c_set_wins_irq: got %b expected 1", irq0); else n_pass++;
        tick();
        n_checks++; if (rd0 !== 32'h08) $display("FAIL w1c_set_wins: got %h expected 00000008", rd0); else n_pass++;
    endtask

    task automatic test_falling();
        wr_reg(2'd2, 32'h0);
        in1 = 4'hF; repeat (3) tick();
        in1 = 4'h0; repeat (3) tick();
        address = 2'd3;
        tick();
        n_checks++; if (rd1 !== 32'h0F) $display("FAIL falling_edgecap: got %h expected 0000000f", rd1); else n_pass++;
        n_checks++; if (irq1 !== 1'b0) $display("FAIL falling_masked_irq: got %b expected 0", irq1); else n_pass++;
        address = 2'd1;
        tick();
        n_checks++; if (rd1 !== 32'h01) $display("FAIL falling_counter: got %h expected 00000001", rd1); else n_pass++;
        wr_reg(2'd2, 32'h1);
        n_checks++; if (irq1 !== 1'b1) $display("FAIL falling_unmask_irq: got %b expected 1", irq1); else n_pass++;
    endtask

    task automatic test_any_saturate();
        for (int i = 0; i < 5; i++) begin
            in2[0] = ~in2[0];
            tick(); tick();
        end
        tick(); tick();
        address = 2'd1;
        tick();
        n_checks++; if (rd2 !== 32'h3) $display("FAIL any_saturate: got %h expected 00000003", rd2); else n_pass++;
        in2[0] = ~in2[0];
        tick(); tick();
        wr_reg(2'd1, 32'h0);
        tick();
        n_checks++; if (rd2 !== 32'h1) $display("FAIL any_clear_on_event: got %h expected 00000001", rd2); else n_pass++;
    endtask

    task automatic test_data_path();
        in0 = 8'hA5; address = 2'd0;
        tick(); tick();
        n_checks++; if (rd0 !== 32'h08) $display("FAIL data_latency2: got %h expected 00000008", rd0); else n_pass++;
        tick();
        n_checks++; if (rd0 !== 32'hA5) $display("FAIL data_latency3: got %h expected 000000a5", rd0); else n_pass++;
        wr_reg(2'd0, 32'hFFFF_FFFF);
        n_checks++; if (rd0 !== 32'hA5) $display("FAIL data_write_ignored: got %h expected 000000a5", rd0); else n_pass++;
        for (int a = 1; a < 4; a++) begin
            address = a[1:0];
            tick();
            for (int m = 0; m < 3; m++) begin
                n_checks++;
                if (dut_rd(m) !== m_rd[m])
                    $display("FAIL data_write_regs[%0d] addr %0d: got %h expected %h", m, a, dut_rd(m), m_rd[m]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in0     = 8'($urandom);
            in1     = 4'($urandom);
            in2     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : in2;
            address = 2'($urandom);
            writedata = $urandom;
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = ($urandom_range(0, 4) == 0);
            tick();
            for (int m = 0; m < 3; m++) begin
                n_checks++;
                if (dut_rd(m) !== m_rd[m])
                    $display("FAIL random_readdata[%0d] cyc %0d: got %h expected %h", m, c, dut_rd(m), m_rd[m]);
                else n_pass++;
                n_checks++;
                if (dut_irq(m) !== ((m_ec[m] & m_mk[m]) != 0))
                    $display("FAIL random_irq[%0d] cyc %0d: got %b expected %b", m, c, dut_irq(m), ((m_ec[m] & m_mk[m]) != 0));
                else n_pass++;
            end
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_reset_mid();
        in0 = 8'h00;
        wr_reg(2'd2, 32'hFF);
        repeat (3) tick();
        wr_reg(2'd3, 32'hFF);
        in0 = 8'hFF;
        repeat (3) tick();
        address = 2'd3;
        tick();
        n_checks++; if (irq0 !== 1'b1 || rd0 !== 32'hFF)
            $display("FAIL midreset_setup: irq %b rd %h expected 1 000000ff", irq0, rd0); else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (rd0 !== 32'd0 || rd1 !== 32'd0 || rd2 !== 32'd0)
            $display("FAIL midreset_readdata: got %h %h %h expected 0", rd0, rd1, rd2); else n_pass++;
        n_checks++; if ({irq0, irq1, irq2} !== 3'b000)
            $display("FAIL midreset_irq: got %b expected 000", {irq0, irq1, irq2}); else n_pass++;
        @(posedge clk); #1;
        model_reset();
        reset = 1'b0;
        repeat (3) tick();
        tick();
        n_checks++; if (rd0 !== 32'hFF) $display("FAIL postreset_capture: got %h expected 000000ff", rd0); else n_pass++;
        n_checks++; if (irq0 !== 1'b0) $display("FAIL postreset_mask_cleared: got %b expected 0", irq0); else n_pass++;
        address = 2'd1;
        tick();
        n_checks++; if (rd0 !== 32'h1) $display("FAIL postreset_counter: got %h expected 00000001", rd0); else n_pass++;
        n_checks++; if (rd0 !== m_rd[0]) $display("FAIL postreset_model: got %h expected %h", rd0, m_rd[0]); else n_pass++;
    endtask

    initial begin
        dwv[0] = 8; modev[0] = 0; cwv[0] = 16;
        dwv[1] = 4; modev[1] = 1; cwv[1] = 16;
        dwv[2] = 8; modev[2] = 2; cwv[2] = 2;
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        in0 = 8'h00; in1 = 4'h0; in2 = 8'h00;
        model_reset();
        test_reset();
        test_rising_irq();
        test_w1c();
        test_falling();
        test_any_saturate();
        test_data_path();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
